// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port between requesters.
// A tag pipeline matched to the ROM latency routes each word back to its issuer.
module rom_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int ROM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic                    freeze,
    input  logic [DATA_W-1:0]       rom_value,
    output logic [ADDR_W-1:0]       rom_address,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [N_REQ*DATA_W-1:0] rsp_data,
    output logic                    busy
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [ID_W-1:0]        last;
    logic [ID_W-1:0]        win;
    logic                   found;
    logic                   grant;
    logic                   busy_next;
    logic [ROM_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]        tag_id [ROM_LATENCY];

    // Two passes: indices above the last winner first, then wrap around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && ID_W'(i) > last) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && ID_W'(i) <= last) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end

    assign grant = found && !freeze;

    // The output-stage tag is delivered this edge, so it does not count.
    always_comb begin
        busy_next = grant;
        for (int k = 0; k < ROM_LATENCY - 1; k++) begin
            busy_next = busy_next | tag_v[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_address <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            busy        <= 1'b0;
            last        <= ID_W'(N_REQ - 1);
            tag_v       <= '0;
            for (int k = 0; k < ROM_LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            busy      <= busy_next;
            if (grant) begin
                last <= win;
                for (int i = 0; i < N_REQ; i++) begin
                    if (win == ID_W'(i)) begin
                        gnt[i]      <= 1'b1;
                        rom_address <= addr[i*ADDR_W +: ADDR_W];
                    end
                end
            end
            tag_v[0]  <= grant;
            tag_id[0] <= win;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            if (tag_v[ROM_LATENCY-1]) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (tag_id[ROM_LATENCY-1] == ID_W'(i)) begin
                        rsp_valid[i]                 <= 1'b1;
                        rsp_data[i*DATA_W +: DATA_W] <= rom_value;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: a request-level model predicts grants and
// responses; a monitor compares every cycle against the queued expectations.
module tb_rom_arbiter;

    localparam int N   = 3;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] addr = '0;
    logic            freeze = 1'b0;
    logic [DW-1:0]   rom_value;
    logic [AW-1:0]   rom_address;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [N*DW-1:0] rsp_data;
    logic            busy;

    rom_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .freeze(freeze),
        .rom_value(rom_value), .rom_address(rom_address), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // ROM with LAT edges from address update to sampled data.
    logic [DW-1:0] mem [256];
    always @(posedge clk) rom_value <= mem[rom_address];

    typedef struct {
        int          due;
        int          id;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t gq[$];
    ent_t rq[$];
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   last_m = N - 1;
    int   prev_w = -1;
    logic [AW-1:0] exp_addr = '0;
    logic [N*DW-1:0] exp_data = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (l + k) % N;
            if (((r >> j) & N'(1)) != '0) return j;
        end
        return -1;
    endfunction

    // Drive one cycle of stimulus and record what the model expects from it.
    task automatic drive(input logic r, input logic [N-1:0] rv,
                         input logic fz, input logic [N*AW-1:0] av);
        int w;
        ent_t e;
        @(negedge clk);
        rst = r;
        req = rv;
        freeze = fz;
        addr = av;
        prev_w = -1;
        if (r) begin
            gq.delete();
            rq.delete();
            last_m = N - 1;
        end else if (!fz && rv != '0) begin
            w = pick(rv, last_m);
            last_m = w;
            prev_w = w;
            e.id = w;
            e.a = av[w*AW +: AW];
            e.d = mem[e.a];
            e.due = cyc + 1;
            gq.push_back(e);
            e.due = cyc + 1 + LAT;
            rq.push_back(e);
        end
    endtask

    initial begin
        ent_t e;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                exp_addr = '0;
                exp_data = '0;
                check("rst_gnt", 64'(gnt), 64'd0);
                check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
                check("rst_rom_address", 64'(rom_address), 64'd0);
                check("rst_rsp_data", 64'(rsp_data), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
            end else begin
                eg = '0;
                if (gq.size() > 0 && gq[0].due == cyc) begin
                    e = gq.pop_front();
                    eg = N'(1) << e.id;
                    exp_addr = e.a;
                end
                check("gnt", 64'(gnt), 64'(eg));
                check("rom_address", 64'(rom_address), 64'(exp_addr));
                er = '0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    e = rq.pop_front();
                    er = N'(1) << e.id;
                    exp_data[e.id*DW +: DW] = e.d;
                end
                check("rsp_valid", 64'(rsp_valid), 64'(er));
                check("rsp_data", 64'(rsp_data), 64'(exp_data));
                check("busy", 64'(busy), 64'(rq.size() > 0));
            end
        end
    end

    initial begin
        logic [N*AW-1:0] av;
        logic [N-1:0]    rv;
        logic [N-1:0]    rprev;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        mem[5] = 16'hA5A5;
        av = '0;

        repeat (3) drive(1'b1, '0, 1'b0, av);
        repeat (10) drive(1'b0, '0, 1'b0, av);

        // Single read of address 5.
        av[0 +: AW] = 8'h05;
        drive(1'b0, 3'b001, 1'b0, av);
        repeat (LAT + 2) drive(1'b0, '0, 1'b0, av);

        // Everyone requesting: grants rotate.
        av = {8'h30, 8'h20, 8'h10};
        repeat (9) drive(1'b0, 3'b111, 1'b0, av);
        repeat (LAT + 2) drive(1'b0, '0, 1'b0, av);

        // Freeze right after a grant; in-flight read still returns.
        drive(1'b0, 3'b001, 1'b0, av);
        repeat (LAT + 2) drive(1'b0, 3'b001, 1'b1, av);
        repeat (2) drive(1'b0, 3'b001, 1'b0, av);
        repeat (LAT + 2) drive(1'b0, '0, 1'b0, av);

        // Reset one cycle after a grant discards the read.
        drive(1'b0, 3'b010, 1'b0, av);
        drive(1'b1, 3'b011, 1'b0, av);
        drive(1'b0, 3'b011, 1'b0, av);
        repeat (LAT + 2) drive(1'b0, '0, 1'b0, av);

        // Randomized traffic with occasional freeze and reset.
        rprev = '0;
        for (int n = 0; n < 400; n++) begin
            rv = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (!rprev[i] || prev_w == i) av[i*AW +: AW] = AW'($urandom);
            end
            drive($urandom_range(0, 99) == 0, rv,
                  $urandom_range(0, 4) == 0, av);
            rprev = rv;
        end

        repeat (LAT + 3) drive(1'b0, '0, 1'b0, av);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one synchronous instruction-ROM read port between N requesters, e.g. several cpu cores or a cpu plus a debug/loader reader. It accepts one address per cycle, drives the ROM address register, tracks in-flight reads through a latency-matched tag pipeline, and returns each word to the requester that issued it. A freeze input stalls new grants so the ROM can be rewritten safely, while reads already in flight still complete.

## Interface
- N_REQ, 2, number of requesters (2..4)
- ADDR_W, 8, ROM address width
- DATA_W, 16, ROM word width
- ROM_LATENCY, 1, clk edges from a rom_address update to the edge that samples the matching rom_value (>= 1)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester read request, level; held until granted
- addr  in  N_REQ*ADDR_W  per-requester address, slice i = addr[i*ADDR_W+:ADDR_W]; stable while req[i] is high
- freeze  in  1  when high, no new grants are issued
- rom_value  in  DATA_W  ROM read data
- rom_address  out  ADDR_W  registered ROM address
- gnt  out  N_REQ  one-hot, one-cycle grant pulse; addr slice accepted on that edge
- rsp_valid  out  N_REQ  one-cycle pulse, rsp_data slice i is new
- rsp_data  out  N_REQ*DATA_W  per-requester registered read data, held until the next response
- busy  out  1  high while any read is in flight

## Operation
- Reset: rom_address=0, gnt=0, rsp_valid=0, rsp_data=0, busy=0, priority pointer last=N_REQ-1, tag pipeline cleared.
- Arbitration at each edge when !freeze and any req is high:
  - Winner is the first i with req[i]=1, scanning last+1, last+2, … mod N_REQ.
  - Registers: gnt=onehot(i), rom_address=addr[i], last=i, and tag {valid=1, id=i} enters the pipeline.
- No eligible request, or freeze=1: gnt=0, rom_address holds, last holds, and an invalid tag enters the pipeline.
- Tag pipeline: ROM_LATENCY stages.
  - When a valid tag with id j reaches the output stage at an edge, rsp_data[j] <= rom_value and rsp_valid[j] <= 1 for that cycle only.
  - Other rsp_data slices hold; all other rsp_valid bits are 0.
- busy = OR of all tag valid bits, including the one being registered this edge (registered).
- A requester may keep req high after gnt to issue back-to-back reads. It must update addr in the cycle after gnt, or the same address is read again.
- A requester dropping req before it is granted is legal; no read is issued.
- freeze does not cancel reads already in flight. busy falls once the last one returns.
- Reset mid-operation: all in-flight reads are discarded, no rsp_valid is produced for them, and every output returns to its reset value at that edge.

## Timing
- Grant latency: req[i] high before edge E with i winning → gnt[i]=1 and rom_address=addr[i] in the cycle after E.
- Response latency: rsp_valid[i] is high in the cycle after edge E+ROM_LATENCY. That is ROM_LATENCY cycles after the gnt pulse.
- Throughput: one grant per cycle total. Responses are returned in grant order and never overlap.
- Fairness:
  - With all N_REQ requesting continuously, grants rotate 0,1,…,N_REQ-1,0,…
  - No requester waits more than N_REQ-1 grant cycles.
- freeze is sampled at the same edge as req. freeze=1 at edge E means no grant is registered at E.
- Simultaneous events at one edge are independent: a new grant and a response delivery can both occur, to the same or different requesters.

## Test plan
- Reset then idle, N_REQ=2, ROM_LATENCY=1 → all outputs 0, busy=0 for 10 cycles.
- req[0]=1 addr[0]=8'h05, ROM returns 16'hA5A5 for address 5 → gnt[0] pulse next cycle, rom_address=5, rsp_valid[0] one cycle later with rsp_data[0]=16'hA5A5.
- req=2'b11 held for 6 cycles, addr[0]=8'h10, addr[1]=8'h20 → gnt sequence 01,10,01,10,01,10; rom_address alternates 10/20; each rsp_valid pulse carries the matching words.
- ROM_LATENCY=3, req[1] continuous for 4 cycles with addr stepping 0,1,2,3 → rsp_valid[1] pulses on 4 consecutive cycles starting 3 cycles after the first gnt, data in address order; busy high throughout.
- freeze=1 one cycle after a grant with req[0] still high → no gnt while frozen; the in-flight read still returns; busy drops; granting resumes the cycle after freeze falls.
- rst=1 one cycle after a grant with ROM_LATENCY=2 → no rsp_valid for that read; outputs at reset values; the first grant after reset goes to requester 0 when both request.
